// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter: FSM states, counter widths,
// and the FIFO data width that both the FIFO and its write arbiter agree on.
package fifo_arb_pkg;

  localparam int unsigned FIFO_DSIZE = 8;
  localparam int unsigned STALL_W    = 16;

  typedef enum logic {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } arb_state_e;

  // Beat counter must be able to hold MAX_BURST itself.
  function automatic int unsigned beat_w(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above the pointer,
// wrapping modulo NREQ; returns one-hot grant, its index and an any-request flag.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [idx_w(NREQ)-1:0]  i_ptr,
  output logic [NREQ-1:0]         o_gnt,
  output logic [idx_w(NREQ)-1:0]  o_idx,
  output logic                    o_any
);

  localparam int unsigned IdxW = idx_w(NREQ);

  logic [31:0]     w_sum;
  logic [IdxW-1:0] w_i;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_sum = '0;
    w_i   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_sum = 32'(i_ptr) + k;
      w_i   = IdxW'(w_sum % NREQ);
      if (!o_any && i_req[w_i]) begin
        o_gnt[w_i] = 1'b1;
        o_idx      = w_i;
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding a single FIFO write port: one owner at a time,
// bursts end on last or MAX_BURST words, and FIFO-full back-pressure is counted.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DSIZE     = FIFO_DSIZE,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                    wclk,
  input  logic                    wrst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_last,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         gnt,
  output logic                    winc,
  output logic [DSIZE-1:0]        wdata,
  input  logic                    wfull,
  output logic [STALL_W-1:0]      stall_cnt
);

  localparam int unsigned BeatW = beat_w(MAX_BURST);
  localparam int unsigned IdxW  = idx_w(NREQ);

  arb_state_e          r_state;
  logic [NREQ-1:0]     r_gnt;
  logic [IdxW-1:0]     r_owner;
  logic [IdxW-1:0]     r_rr_ptr;
  logic [BeatW-1:0]    r_beat;
  logic [STALL_W-1:0]  r_stall;

  logic [NREQ-1:0]     w_arb_gnt;
  logic [IdxW-1:0]     w_arb_idx;
  logic                w_arb_any;
  logic                w_in_burst;
  logic                w_own_valid;
  logic                w_own_last;
  logic                w_accept;
  logic                w_end;
  logic [BeatW-1:0]    w_beat_nxt;
  logic [IdxW-1:0]     w_next_ptr;
  logic [DSIZE-1:0]    w_own_data;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  assign w_in_burst  = (r_state == StBurst);
  assign w_own_valid = req_valid[r_owner];
  assign w_own_last  = req_last[r_owner];
  assign w_own_data  = req_data[32'(r_owner) * DSIZE +: DSIZE];
  assign w_accept    = w_in_burst && w_own_valid && !wfull;
  assign w_beat_nxt  = r_beat + 1'b1;
  assign w_end       = w_accept && (w_own_last || (w_beat_nxt == BeatW'(MAX_BURST)));
  assign w_next_ptr  = (r_owner == IdxW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

  // Gated by wrst so the write side is quiet in the very cycle reset rises.
  assign winc      = !wrst && w_accept;
  assign req_ready = (!wrst && w_in_burst && !wfull) ? r_gnt : '0;
  assign wdata     = (!wrst && w_in_burst) ? w_own_data : '0;
  assign gnt       = r_gnt;
  assign stall_cnt = r_stall;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_state  <= StIdle;
      r_gnt    <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_beat   <= '0;
      r_stall  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_arb_any) begin
            r_gnt   <= w_arb_gnt;
            r_owner <= w_arb_idx;
            r_beat  <= '0;
            r_state <= StBurst;
          end
        end
        StBurst: begin
          if (w_end) begin
            r_gnt    <= '0;
            r_beat   <= '0;
            r_rr_ptr <= w_next_ptr;
            r_state  <= StIdle;
          end else if (w_accept) begin
            r_beat <= w_beat_nxt;
          end
          // Only a stalled owner that actually has a word counts as a stall.
          if (wfull && w_own_valid && (r_stall != '1)) begin
            r_stall <= r_stall + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester BFMs driven per cycle, a queue
// captures every FIFO write, and each observation is compared to hand-derived values.
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrst;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  gnt;
  logic        winc;
  logic [7:0]  wdata;
  logic        wfull;
  logic [15:0] stall_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cnt[4];
  int          lim[4];
  logic [7:0]  base[4];
  logic [3:0]  en;
  int          last_mode;
  logic [7:0]  fifo_q[$];

  fifo_wr_arbiter #(
    .DSIZE     (8),
    .NREQ      (4),
    .MAX_BURST (4)
  ) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .gnt       (gnt),
    .winc      (winc),
    .wdata     (wdata),
    .wfull     (wfull),
    .stall_cnt (stall_cnt)
  );

  always #5 wclk = ~wclk;

  // Inputs are stable from just after posedge, so negedge sees what the FIFO will latch.
  always @(negedge wclk) begin
    if (winc) fifo_q.push_back(wdata);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_fifo(input string tag, input int k, input logic [7:0] exp);
    check(tag, (k < fifo_q.size()) ? {24'h0, fifo_q[k]} : 32'hdead_beef, {24'h0, exp});
  endtask

  // One clock of requester activity: drive, check, then advance past the edge.
  task automatic step(input string tag, input logic [3:0] exp_gnt, input logic exp_winc);
    logic [3:0] acc;
    for (int i = 0; i < 4; i++) begin
      req_valid[i]         = en[i] && (cnt[i] < lim[i]);
      req_data[i*8 +: 8]   = base[i] + 8'(cnt[i]);
      req_last[i]          = (last_mode == 1) ? (cnt[i] % 2 == 1) :
                             (last_mode == 2) ? (cnt[i] == lim[i] - 1) : 1'b0;
    end
    #1;
    check({tag, "_gnt"}, {28'h0, gnt}, {28'h0, exp_gnt});
    check({tag, "_winc"}, {31'h0, winc}, {31'h0, exp_winc});
    check({tag, "_ready"}, {28'h0, req_ready}, {28'h0, exp_gnt & {4{~wfull}}});
    acc = req_valid & req_ready;
    @(posedge wclk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) cnt[i]++;
  endtask

  task automatic reset_pulse();
    wrst = 1'b1;
    @(posedge wclk);
    #1;
    wrst = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    fifo_q.delete();
  endtask

  initial begin
    logic [3:0] b_gnt[14];
    logic [3:0] c_gnt[9];
    logic       c_winc[9];

    wrst      = 1'b1;
    req_valid = 4'hf;
    req_last  = 4'h0;
    req_data  = 32'h44332211;
    wfull     = 1'b0;
    en        = 4'h0;
    last_mode = 0;
    for (int i = 0; i < 4; i++) begin
      cnt[i]  = 0;
      lim[i]  = 0;
      base[i] = 8'h00;
    end

    repeat (2) @(posedge wclk);
    #1;
    check("rst_gnt", {28'h0, gnt}, 32'h0);
    check("rst_winc", {31'h0, winc}, 32'h0);
    check("rst_ready", {28'h0, req_ready}, 32'h0);
    check("rst_wdata", {24'h0, wdata}, 32'h0);
    check("rst_stall", {16'h0, stall_cnt}, 32'h0);
    wrst = 1'b0;

    // req1 three-word burst with last on the third word
    en = 4'b0010; base[1] = 8'hA1; lim[1] = 3; last_mode = 2;
    step("a_idle", 4'b0000, 1'b0);
    repeat (3) step("a_beat", 4'b0010, 1'b1);
    step("a_done", 4'b0000, 1'b0);
    check("a_fifo_n", fifo_q.size(), 3);
    check_fifo("a_fifo0", 0, 8'hA1);
    check_fifo("a_fifo1", 1, 8'hA2);
    check_fifo("a_fifo2", 2, 8'hA3);
    fifo_q.delete();

    // Reset mid-burst, re-arbitration after release, then a held grant with no valid
    en = 4'b0001; base[0] = 8'h50; lim[0] = 100; last_mode = 0;
    step("r_idle", 4'b0000, 1'b0);
    step("r_burst", 4'b0001, 1'b1);
    wrst = 1'b1;
    #1;
    check("r_mid_gnt", {28'h0, gnt}, 32'h0);
    check("r_mid_winc", {31'h0, winc}, 32'h0);
    check("r_mid_ready", {28'h0, req_ready}, 32'h0);
    @(posedge wclk);
    #1;
    wrst = 1'b0;
    step("r_rel", 4'b0000, 1'b0);
    step("r_regnt", 4'b0001, 1'b1);
    en = 4'b0000;
    repeat (3) step("r_hold", 4'b0001, 1'b0);
    reset_pulse();

    // All four continuously valid, two-word bursts
    en = 4'b1111; last_mode = 1;
    for (int i = 0; i < 4; i++) begin
      base[i] = 8'(16 * (i + 1));
      lim[i]  = 100;
    end
    b_gnt = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0,
              4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1};
    for (int c = 0; c < 14; c++) step("b_rr", b_gnt[c], b_gnt[c] != 4'h0);
    check("b_fifo_n", fifo_q.size(), 9);
    check_fifo("b_fifo0", 0, 8'h10);
    check_fifo("b_fifo1", 1, 8'h11);
    check_fifo("b_fifo2", 2, 8'h20);
    check_fifo("b_fifo5", 5, 8'h31);
    check_fifo("b_fifo7", 7, 8'h41);
    check_fifo("b_fifo8", 8, 8'h12);
    reset_pulse();

    // req2 six words, no last: split at MAX_BURST, re-granted after one idle cycle
    en = 4'b0100; base[2] = 8'hC0; lim[2] = 6; last_mode = 0;
    for (int i = 0; i < 4; i++) if (i != 2) lim[i] = 0;
    c_gnt  = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h4};
    c_winc = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 9; c++) step("c_split", c_gnt[c], c_winc[c]);
    check("c_fifo_n", fifo_q.size(), 6);
    for (int k = 0; k < 6; k++) check_fifo("c_fifo", k, 8'hC0 + 8'(k));
    reset_pulse();

    // wfull held five cycles mid-burst
    en = 4'b0001; base[0] = 8'hD0; lim[0] = 3; last_mode = 2;
    step("d_idle", 4'b0000, 1'b0);
    step("d_beat0", 4'b0001, 1'b1);
    wfull = 1'b1;
    repeat (5) step("d_stall", 4'b0001, 1'b0);
    check("d_stall_cnt", {16'h0, stall_cnt}, 32'd5);
    wfull = 1'b0;
    step("d_beat1", 4'b0001, 1'b1);
    step("d_beat2", 4'b0001, 1'b1);
    step("d_done", 4'b0000, 1'b0);
    check("d_fifo_n", fifo_q.size(), 3);
    check_fifo("d_fifo0", 0, 8'hD0);
    check_fifo("d_fifo1", 1, 8'hD1);
    check_fifo("d_fifo2", 2, 8'hD2);
    fifo_q.delete();

    // Last word presented while full: burst must not end until it is accepted
    en = 4'b0010; base[1] = 8'hE0; lim[1] = 2; cnt[1] = 0; last_mode = 2;
    step("e_idle", 4'b0000, 1'b0);
    step("e_beat0", 4'b0010, 1'b1);
    wfull = 1'b1;
    repeat (2) step("e_full_last", 4'b0010, 1'b0);
    wfull = 1'b0;
    step("e_last", 4'b0010, 1'b1);
    step("e_done", 4'b0000, 1'b0);
    check("e_stall_cnt", {16'h0, stall_cnt}, 32'd7);
    check("e_fifo_n", fifo_q.size(), 2);
    check_fifo("e_fifo0", 0, 8'hE0);
    check_fifo("e_fifo1", 1, 8'hE1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
